cpu_io_unit: RTL and testbench
==============================

// Module: cpu_io_unit
// PURPOSE
//  Parametrised programmed-I/O unit for the hardwired CPU; successor to the fixed single INPR/OUTR pair.
//  Provides NUM_CH input/output channels, each with its own INPR/OUTR register and FGI/FGO flags.
//  Devices connect through valid/ready handshakes; the CPU uses INP/OUT/SKI/SKO/ION/IOF strobes.
//  A global IEN drives a prioritised interrupt request into the control unit.
// PARAMETERS
//  DATA_W   16  width of each INPR/OUTR register and of the data buses
//  NUM_CH   2   number of I/O channels (1..16)
//  CH_W     (NUM_CH>1 ? $clog2(NUM_CH) : 1)  channel-select width (derived)
// PORTS
//  clk            in   1             system clock, rising edge
//  reset          in   1             asynchronous, active-low reset
//  dev_in_data    in   NUM_CH*DATA_W device->INPR data; channel c occupies [c*DATA_W +: DATA_W]
//  dev_in_valid   in   NUM_CH        device input word valid
//  dev_in_ready   out  NUM_CH        INPR[c] can accept a word (= ~FGI[c])
//  dev_out_data   out  NUM_CH*DATA_W OUTR contents, same packing as dev_in_data
//  dev_out_valid  out  NUM_CH        OUTR[c] holds a word not yet taken by the device (= ~FGO[c])
//  dev_out_ready  in   NUM_CH        device accepts the OUTR word
//  cpu_ch_sel     in   CH_W          channel addressed by the current I/O instruction
//  cpu_inp        in   1             INP strobe, one cycle
//  cpu_out        in   1             OUT strobe, one cycle
//  cpu_out_data   in   DATA_W        AC value written by OUT
//  cpu_in_data    out  DATA_W        INPR[cpu_ch_sel], combinational
//  cpu_fgi        out  1             FGI[cpu_ch_sel] (for SKI)
//  cpu_fgo        out  1             FGO[cpu_ch_sel] (for SKO)
//  cpu_ion        in   1             ION strobe: set IEN
//  cpu_iof        in   1             IOF strobe: clear IEN
//  cpu_irq_ack    in   1             interrupt cycle entered: clear IEN
//  irq            out  1             IEN & |(FGI | FGO)
//  irq_ch         out  CH_W          lowest-index channel with FGI or FGO set; 0 when none
// BEHAVIOUR
//  Reset (reset=0, async): INPR=0, OUTR=0, FGI=0, FGO=1 (all channels), IEN=0.
//   Therefore dev_in_ready=all 1, dev_out_valid=0, irq=0. No clock is needed for reset to take effect.
//  Input path, per channel c:
//   - dev_in_valid[c] & dev_in_ready[c] at edge: INPR[c]<=data, FGI[c]<=1. The word is visible next cycle.
//   - cpu_inp with sel=c and FGI[c]=1: cpu_in_data is valid in the same cycle; FGI[c]<=0 at the edge.
//   - cpu_inp with FGI[c]=0: no state change; cpu_in_data still shows the stale INPR[c].
//   - A device write and a CPU read of the same channel cannot collide, because ready=~FGI.
//  Output path, per channel c (2-state FSM encoded by FGO):
//   - IDLE (FGO=1): cpu_out with sel=c causes OUTR[c]<=cpu_out_data and FGO[c]<=0, moving to BUSY.
//   - BUSY (FGO=0): dev_out_valid=1 and OUTR is held stable. dev_out_ready causes FGO[c]<=1, back to IDLE.
//   - cpu_out in BUSY is ignored: OUTR is not overwritten. Software must test SKO first.
//   - Minimum turnaround is 2 cycles per word: OUT, then the ready cycle.
//  cpu_inp and cpu_out may assert in the same cycle; both act on cpu_ch_sel.
//  cpu_ch_sel >= NUM_CH: strobes are ignored; cpu_in_data, cpu_fgi and cpu_fgo read 0.
//  IEN: next IEN = (IEN | cpu_ion) & ~cpu_iof & ~cpu_irq_ack. Clear wins over set.
//  irq and irq_ch are combinational from registers only (glitch-free), so irq asserts the cycle after the flag sets.
//  Reset mid-transfer: handshake state is lost; dev_out_valid drops asynchronously and the device must discard.
// STRUCTURE
//  cpu_io_defs.vh: default DATA_W/NUM_CH, the CH_W macro, and reset-value constants (FGO_RST=1, IEN_RST=0).
//  Sub-module io_channel: one INPR/OUTR/FGI/FGO slice with both handshakes, instantiated NUM_CH times by generate.
//  Top level holds the IEN register, the select/read mux and the priority encoder for irq_ch.
// TESTING
//  1 Reset asserted mid-cycle -> dev_in_ready=2'b11, dev_out_valid=0, FGO=1, irq=0 before the next clk edge.
//  2 ch1 dev_in 16'hA5A5 valid 1 cycle; then cpu_inp sel=1 -> cpu_in_data=A5A5, cpu_fgi 1->0, dev_in_ready[1] back to 1.
//  3 cpu_out sel=0 data 16'h1234; dev_out_ready held 0 for 3 cycles; second cpu_out 16'hFFFF issued
//     -> dev_out_data[0] stays 1234; ready=1 -> FGO[0]=1.
//  4 ION; ch1 input arrives and ch0 is BUSY -> irq=1, irq_ch=1; cpu_irq_ack together with cpu_ion -> IEN=0, irq=0.
//  5 NUM_CH=3, sel=3, cpu_inp/cpu_out pulsed -> no flag or register changes; cpu_in_data=0.
//  6 Back-to-back streaming, 8 words on ch0, device ready always 1, CPU polls SKO -> all words delivered in order, none lost.

Source files
------------

// File: rtl/cpu_io_unit_pkg.sv
// Shared types and constants for the programmed-I/O unit.
// No logic of its own; defaults, reset values and the channel-select width helper.
// No flow control here; see cpu_io_unit and cpu_io_unit_io_channel.
package cpu_io_unit_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int NUM_CH_DEF = 2;

    // Output side comes out of reset ready for the CPU (FGO set); interrupts masked.
    localparam logic FGO_RST = 1'b1;
    localparam logic IEN_RST = 1'b0;

    // Output-path state; the encoding is the FGO flag itself.
    typedef enum logic {
        OUT_BUSY = 1'b0,
        OUT_IDLE = 1'b1
    } out_state_e;

    // A single channel still needs a one-bit select.
    function automatic int ch_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/cpu_io_unit_io_channel.sv
// One I/O channel: INPR/FGI input holding register and OUTR/FGO output FSM.
// Device word visible to the CPU one cycle after acceptance; OUT word offered next cycle.
// Single-entry each way: dev_in_ready = ~FGI, and OUTR is frozen while a word is pending.
module cpu_io_unit_io_channel
    import cpu_io_unit_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_ni,
    input  logic [DATA_W-1:0] dev_in_dat_i,
    input  logic              dev_in_vld_i,
    input  logic              dev_out_rdy_i,
    input  logic              cpu_inp_i,
    input  logic              cpu_out_i,
    input  logic [DATA_W-1:0] cpu_out_dat_i,
    output logic [DATA_W-1:0] inpr_o,
    output logic [DATA_W-1:0] outr_o,
    output logic              fgi_o,
    output logic              fgo_o
);

    logic [DATA_W-1:0] inpr_q;
    logic [DATA_W-1:0] outr_q;
    logic              fgi_q;
    out_state_e        out_state_q;

    // Input register: the device fills it only when empty, an INP drains the flag.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            inpr_q <= '0;
            fgi_q  <= 1'b0;
        end else if (dev_in_vld_i && !fgi_q) begin
            inpr_q <= dev_in_dat_i;
            fgi_q  <= 1'b1;
        end else if (cpu_inp_i && fgi_q) begin
            fgi_q  <= 1'b0;
        end
    end

    // Output FSM: OUT loads OUTR only when idle; the device handshake returns it to idle.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            outr_q      <= '0;
            out_state_q <= out_state_e'(FGO_RST);
        end else begin
            case (out_state_q)
                OUT_IDLE: begin
                    if (cpu_out_i) begin
                        outr_q      <= cpu_out_dat_i;
                        out_state_q <= OUT_BUSY;
                    end
                end
                OUT_BUSY: begin
                    if (dev_out_rdy_i) begin
                        out_state_q <= OUT_IDLE;
                    end
                end
                default: out_state_q <= OUT_IDLE;
            endcase
        end
    end

    assign inpr_o = inpr_q;
    assign outr_o = outr_q;
    assign fgi_o  = fgi_q;
    assign fgo_o  = (out_state_q == OUT_IDLE);

endmodule

// File: rtl/cpu_io_unit.sv
// Multi-channel programmed-I/O unit: per-channel INPR/OUTR, CPU select mux, IEN and irq priority.
// CPU reads are combinational; flags and irq change one cycle after the causing edge.
// Per-channel single-word buffering; devices are throttled by dev_in_ready / dev_out_valid.
module cpu_io_unit
    import cpu_io_unit_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int CH_W   = ch_w(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH*DATA_W-1:0] dev_in_data,
    input  logic [NUM_CH-1:0]        dev_in_valid,
    output logic [NUM_CH-1:0]        dev_in_ready,
    output logic [NUM_CH*DATA_W-1:0] dev_out_data,
    output logic [NUM_CH-1:0]        dev_out_valid,
    input  logic [NUM_CH-1:0]        dev_out_ready,
    input  logic [CH_W-1:0]          cpu_ch_sel,
    input  logic                     cpu_inp,
    input  logic                     cpu_out,
    input  logic [DATA_W-1:0]        cpu_out_data,
    output logic [DATA_W-1:0]        cpu_in_data,
    output logic                     cpu_fgi,
    output logic                     cpu_fgo,
    input  logic                     cpu_ion,
    input  logic                     cpu_iof,
    input  logic                     cpu_irq_ack,
    output logic                     irq,
    output logic [CH_W-1:0]          irq_ch
);

    logic [DATA_W-1:0] inpr [NUM_CH];
    logic [DATA_W-1:0] outr [NUM_CH];
    logic [NUM_CH-1:0] fgi;
    logic [NUM_CH-1:0] fgo;
    logic              ien_q;
    logic              ien_d;

    // An out-of-range select matches no channel, so its strobes are dropped here.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic hit;
        assign hit = (cpu_ch_sel == CH_W'(c));

        cpu_io_unit_io_channel #(.DATA_W(DATA_W)) u_ch (
            .clk           (clk),
            .rst_ni        (reset),
            .dev_in_dat_i  (dev_in_data[c*DATA_W +: DATA_W]),
            .dev_in_vld_i  (dev_in_valid[c]),
            .dev_out_rdy_i (dev_out_ready[c]),
            .cpu_inp_i     (cpu_inp & hit),
            .cpu_out_i     (cpu_out & hit),
            .cpu_out_dat_i (cpu_out_data),
            .inpr_o        (inpr[c]),
            .outr_o        (outr[c]),
            .fgi_o         (fgi[c]),
            .fgo_o         (fgo[c])
        );

        assign dev_out_data[c*DATA_W +: DATA_W] = outr[c];
    end

    assign dev_in_ready  = ~fgi;
    assign dev_out_valid = ~fgo;

    // CPU-side read mux; reads zero when the select names no channel.
    always_comb begin
        cpu_in_data = '0;
        cpu_fgi     = 1'b0;
        cpu_fgo     = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (cpu_ch_sel == CH_W'(c)) begin
                cpu_in_data = inpr[c];
                cpu_fgi     = fgi[c];
                cpu_fgo     = fgo[c];
            end
        end
    end

    // Interrupt enable next state: any clear beats a simultaneous set.
    always_comb begin
        ien_d = (ien_q | cpu_ion) & ~cpu_iof & ~cpu_irq_ack;
    end

    // Interrupt enable register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ien_q <= IEN_RST;
        end else begin
            ien_q <= ien_d;
        end
    end

    // Priority encoder over registered flags only: lowest requesting channel wins.
    always_comb begin
        irq_ch = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (fgi[c] | fgo[c]) begin
                irq_ch = CH_W'(c);
            end
        end
    end

    assign irq = ien_q & (|(fgi | fgo));

endmodule

// File: tb/tb_cpu_io_unit.sv
// Self-checking bench for cpu_io_unit with three channels (exercises an out-of-range select).
// Directed scenarios plus randomized traffic against a flag/queue reference model.
// Device words are tracked through per-channel queues to check ordering end to end.
module tb_cpu_io_unit;

    localparam int DW = 16;
    localparam int NC = 3;
    localparam int CW = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NC*DW-1:0]  dev_in_data;
    logic [NC-1:0]     dev_in_valid;
    logic [NC-1:0]     dev_in_ready;
    logic [NC*DW-1:0]  dev_out_data;
    logic [NC-1:0]     dev_out_valid;
    logic [NC-1:0]     dev_out_ready;
    logic [CW-1:0]     cpu_ch_sel;
    logic              cpu_inp;
    logic              cpu_out;
    logic [DW-1:0]     cpu_out_data;
    logic [DW-1:0]     cpu_in_data;
    logic              cpu_fgi;
    logic              cpu_fgo;
    logic              cpu_ion;
    logic              cpu_iof;
    logic              cpu_irq_ack;
    logic              irq;
    logic [CW-1:0]     irq_ch;

    cpu_io_unit #(.DATA_W(DW), .NUM_CH(NC)) dut (
        .clk           (clk),
        .reset         (reset),
        .dev_in_data   (dev_in_data),
        .dev_in_valid  (dev_in_valid),
        .dev_in_ready  (dev_in_ready),
        .dev_out_data  (dev_out_data),
        .dev_out_valid (dev_out_valid),
        .dev_out_ready (dev_out_ready),
        .cpu_ch_sel    (cpu_ch_sel),
        .cpu_inp       (cpu_inp),
        .cpu_out       (cpu_out),
        .cpu_out_data  (cpu_out_data),
        .cpu_in_data   (cpu_in_data),
        .cpu_fgi       (cpu_fgi),
        .cpu_fgo       (cpu_fgo),
        .cpu_ion       (cpu_ion),
        .cpu_iof       (cpu_iof),
        .cpu_irq_ack   (cpu_irq_ack),
        .irq           (irq),
        .irq_ch        (irq_ch)
    );

    always #5 clk = ~clk;

    // Reference model: word-pending flags, register contents, interrupt enable.
    logic [DW-1:0] m_inpr [NC];
    logic [DW-1:0] m_outr [NC];
    bit            m_fgi  [NC];
    bit            m_fgo  [NC];
    bit            m_ien;
    logic [DW-1:0] q_in   [NC][$];
    logic [DW-1:0] q_out  [NC][$];
    int            n_delivered [NC];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            m_inpr[c] = '0;
            m_outr[c] = '0;
            m_fgi[c]  = 1'b0;
            m_fgo[c]  = 1'b1;
            q_in[c].delete();
            q_out[c].delete();
        end
        m_ien = 1'b0;
    endtask

    task automatic idle_inputs();
        dev_in_valid  = '0;
        dev_out_ready = '0;
        cpu_inp       = 1'b0;
        cpu_out       = 1'b0;
        cpu_ion       = 1'b0;
        cpu_iof       = 1'b0;
        cpu_irq_ack   = 1'b0;
    endtask

    // Compare every observable output against the model.
    task automatic check_outputs();
        int  s;
        bit  any;
        int  first;
        any   = 1'b0;
        first = 0;
        for (int c = NC - 1; c >= 0; c--) begin
            if (m_fgi[c] || m_fgo[c]) begin
                any   = 1'b1;
                first = c;
            end
        end
        for (int c = 0; c < NC; c++) begin
            chk($sformatf("in_ready%0d", c), dev_in_ready[c], !m_fgi[c]);
            chk($sformatf("out_valid%0d", c), dev_out_valid[c], !m_fgo[c]);
            chk($sformatf("out_data%0d", c), dev_out_data[c*DW +: DW], m_outr[c]);
        end
        chk("irq", irq, m_ien && any);
        chk("irq_ch", irq_ch, first);
        s = int'(cpu_ch_sel);
        if (s < NC) begin
            chk("cpu_in_data", cpu_in_data, m_inpr[s]);
            chk("cpu_fgi", cpu_fgi, m_fgi[s]);
            chk("cpu_fgo", cpu_fgo, m_fgo[s]);
        end else begin
            chk("cpu_in_data_oor", cpu_in_data, 0);
            chk("cpu_fgi_oor", cpu_fgi, 0);
            chk("cpu_fgo_oor", cpu_fgo, 0);
        end
    endtask

    // One clock: score handshakes seen before the edge, advance the model, then check.
    task automatic cycle();
        int            s;
        bit            hit;
        logic [DW-1:0] din;
        #1;
        s = int'(cpu_ch_sel);
        for (int c = 0; c < NC; c++) begin
            if (dev_out_valid[c] && dev_out_ready[c]) begin
                if (q_out[c].size() == 0) begin
                    chk($sformatf("out_unexpected%0d", c), 1, 0);
                end else begin
                    chk($sformatf("out_word%0d", c), dev_out_data[c*DW +: DW], q_out[c].pop_front());
                    n_delivered[c]++;
                end
            end
        end
        if (cpu_inp && s < NC && m_fgi[s] && q_in[s].size() != 0) begin
            chk("inp_word", cpu_in_data, q_in[s].pop_front());
        end
        for (int c = 0; c < NC; c++) begin
            hit = (s == c);
            din = dev_in_data[c*DW +: DW];
            if (dev_in_valid[c] && !m_fgi[c]) begin
                m_inpr[c] = din;
                m_fgi[c]  = 1'b1;
                q_in[c].push_back(din);
            end else if (cpu_inp && hit && m_fgi[c]) begin
                m_fgi[c] = 1'b0;
            end
            if (m_fgo[c]) begin
                if (cpu_out && hit) begin
                    m_outr[c] = cpu_out_data;
                    m_fgo[c]  = 1'b0;
                    q_out[c].push_back(cpu_out_data);
                end
            end else if (dev_out_ready[c]) begin
                m_fgo[c] = 1'b1;
            end
        end
        m_ien = (m_ien || cpu_ion) && !cpu_iof && !cpu_irq_ack;
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    // Assert reset between edges and check it takes effect without a clock.
    task automatic do_reset(input string tag);
        cpu_ch_sel = '0;
        reset = 1'b0;
        #2;
        model_reset();
        chk({tag, "_in_ready"}, dev_in_ready, 3'b111);
        chk({tag, "_out_valid"}, dev_out_valid, 3'b000);
        chk({tag, "_fgo"}, cpu_fgo, 1);
        chk({tag, "_irq"}, irq, 0);
        chk({tag, "_out_data"}, dev_out_data, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        check_outputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int start0;
        int budget;
        for (int c = 0; c < NC; c++) n_delivered[c] = 0;
        idle_inputs();
        dev_in_data  = '0;
        cpu_out_data = '0;
        cpu_ch_sel   = '0;
        reset        = 1'b1;
        #1;
        do_reset("rst0");

        // Device word on ch1, then CPU INP sees it in the same cycle.
        dev_in_data[1*DW +: DW] = 16'hA5A5;
        dev_in_valid[1] = 1'b1;
        cycle();
        dev_in_valid[1] = 1'b0;
        cpu_ch_sel = 2'd1;
        cpu_inp = 1'b1;
        #1;
        chk("t2_in_data", cpu_in_data, 16'hA5A5);
        chk("t2_fgi_set", cpu_fgi, 1);
        cycle();
        cpu_inp = 1'b0;
        chk("t2_fgi_clr", cpu_fgi, 0);
        chk("t2_ready_back", dev_in_ready[1], 1);

        // OUT on ch0 held busy; a second OUT must not overwrite OUTR.
        cpu_ch_sel = 2'd0;
        cpu_out = 1'b1;
        cpu_out_data = 16'h1234;
        cycle();
        cpu_out = 1'b0;
        chk("t3_busy", dev_out_valid[0], 1);
        cycle();
        cpu_out = 1'b1;
        cpu_out_data = 16'hFFFF;
        cycle();
        cpu_out = 1'b0;
        cycle();
        chk("t3_hold", dev_out_data[DW-1:0], 16'h1234);
        dev_out_ready[0] = 1'b1;
        cycle();
        dev_out_ready[0] = 1'b0;
        chk("t3_fgo_back", cpu_fgo, 1);

        // Interrupts: ch0 busy, ch1 input pending -> ch1 requests.
        cpu_ion = 1'b1;
        cycle();
        cpu_ion = 1'b0;
        cpu_out = 1'b1;
        cpu_out_data = 16'h0BAD;
        dev_in_data[1*DW +: DW] = 16'h7777;
        dev_in_valid[1] = 1'b1;
        cycle();
        cpu_out = 1'b0;
        dev_in_valid[1] = 1'b0;
        chk("t4_irq", irq, 1);
        chk("t4_irq_ch", irq_ch, 1);
        cpu_irq_ack = 1'b1;
        cpu_ion = 1'b1;
        cycle();
        cpu_irq_ack = 1'b0;
        cpu_ion = 1'b0;
        chk("t4_irq_off", irq, 0);

        // Out-of-range select: strobes ignored, reads are zero.
        cpu_ch_sel = 2'd3;
        cpu_inp = 1'b1;
        cpu_out = 1'b1;
        cpu_out_data = 16'hABCD;
        #1;
        chk("t5_in_data", cpu_in_data, 0);
        chk("t5_fgi", cpu_fgi, 0);
        chk("t5_fgo", cpu_fgo, 0);
        cycle();
        idle_inputs();
        chk("t5_ch1_kept", dev_in_ready[1], 0);
        chk("t5_ch2_idle", dev_out_valid[2], 0);

        // Drain leftovers.
        cpu_ch_sel = 2'd1;
        cpu_inp = 1'b1;
        dev_out_ready = '1;
        cycle();
        idle_inputs();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            dev_in_valid  = NC'($urandom);
            dev_in_data   = {$urandom, $urandom};
            dev_out_ready = NC'($urandom);
            cpu_ch_sel    = CW'($urandom_range(0, 3));
            cpu_inp       = ($urandom_range(0, 2) == 0);
            cpu_out       = ($urandom_range(0, 2) == 0);
            cpu_out_data  = DW'($urandom);
            cpu_ion       = ($urandom_range(0, 7) == 0);
            cpu_iof       = ($urandom_range(0, 11) == 0);
            cpu_irq_ack   = ($urandom_range(0, 11) == 0);
            cycle();
        end
        idle_inputs();
        dev_out_ready = '1;
        cycle();

        // Streaming on ch0 with SKO polling.
        start0 = n_delivered[0];
        cpu_ch_sel = 2'd0;
        for (int i = 0; i < 8; i++) begin
            budget = 0;
            while (!cpu_fgo && budget < 20) begin
                cycle();
                budget++;
            end
            if (budget >= 20) chk("t6_poll_timeout", 1, 0);
            cpu_out = 1'b1;
            cpu_out_data = DW'(16'h5000 + i);
            cycle();
            cpu_out = 1'b0;
        end
        cycle();
        cycle();
        chk("t6_count", n_delivered[0] - start0, 8);
        chk("t6_queue_empty", q_out[0].size(), 0);

        // Reset in the middle of activity.
        dev_out_ready = '0;
        cpu_out = 1'b1;
        cpu_out_data = 16'h4321;
        cpu_ion = 1'b1;
        cycle();
        idle_inputs();
        dev_in_data[2*DW +: DW] = 16'h2222;
        dev_in_valid[2] = 1'b1;
        cycle();
        idle_inputs();
        do_reset("rst_mid");
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
